// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stalls, bubbles, flushes,
// operand forwarding selects and a long-op busy sequencer. Define HAZ_PERF_EN for stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int LONG_LAT = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        use_rs,
    input  logic        use_rt,
    input  logic        dlong,
    input  logic        branch_taken,
    input  logic [4:0]  ern,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  mrn,
    input  logic        mwreg,
    input  logic        mm2reg,
    output logic        wpcir,
    output logic        dbubble,
    output logic        dflush,
    output logic [1:0]  fwda,
    output logic [1:0]  fwdb,
    output logic        busy
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LONG_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       lu;

    // E-stage loads cannot forward from the ALU; they are covered by the load-use stall.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] e_rn,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] m_rn,
        input logic       m_wreg,
        input logic       m_m2reg
    );
        if (src != 5'd0 && e_wreg && !e_m2reg && e_rn == src)
            return 2'b01;
        else if (src != 5'd0 && m_wreg && m_rn == src)
            return m_m2reg ? 2'b11 : 2'b10;
        else
            return 2'b00;
    endfunction

    assign lu = ewreg & em2reg & (ern != 5'd0) &
                ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));

    // NOTE: every output gets its default before the branches, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        wpcir   = 1'b1;
        dbubble = 1'b0;
        dflush  = 1'b0;
        fwda    = 2'b00;
        fwdb    = 2'b00;
        if (resetn) begin
            fwda = fwd_sel(rs, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
            fwdb = fwd_sel(rt, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
            if (state == BUSY || lu) begin
                wpcir   = 1'b0;
                dbubble = 1'b1;
            end else if (branch_taken) begin
                dflush = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
            cnt   <= 4'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!lu && dlong) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= 32'd0;
            flush_cycles <= 32'd0;
        end else begin
            if (!wpcir)
                stall_cycles <= stall_cycles + 32'd1;
            if (dflush)
                flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected output vectors are queued as stimulus
// is driven and popped when outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;

    localparam int LONG_LAT = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] rs, rt, ern, mrn;
    logic       use_rs, use_rt, dlong, branch_taken;
    logic       ewreg, em2reg, mwreg, mm2reg;
    logic       wpcir, dbubble, dflush, busy;
    logic [1:0] fwda, fwdb;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    pipe_hazard_ctrl #(.LONG_LAT(LONG_LAT)) dut (
        .clock(clock), .resetn(resetn),
        .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .dlong(dlong), .branch_taken(branch_taken),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
        .wpcir(wpcir), .dbubble(dbubble), .dflush(dflush),
        .fwda(fwda), .fwdb(fwdb), .busy(busy)
`ifdef HAZ_PERF_EN
        , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0] rs, rt;
        logic       ur, ut, dl, bt;
        logic [4:0] ern;
        logic       ew, em;
        logic [4:0] mrn;
        logic       mw, mm;
    } stim_t;

    typedef struct {
        string      name;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   failed = 0;

    // Observed vector layout: {wpcir, dbubble, dflush, fwda, fwdb, busy}
    logic [7:0] obs;
    assign obs = {wpcir, dbubble, dflush, fwda, fwdb, busy};

    localparam stim_t IDLE = '0;

    // Argument order: rs rt use_rs use_rt dlong branch ern ewreg em2reg mrn mwreg mm2reg
    function automatic stim_t s(input logic [4:0] rs_i, rt_i, input logic ur_i, ut_i, dl_i, bt_i,
                                input logic [4:0] ern_i, input logic ew_i, em_i,
                                input logic [4:0] mrn_i, input logic mw_i, mm_i);
        stim_t t;
        t.rs = rs_i;   t.rt = rt_i;   t.ur = ur_i; t.ut = ut_i;
        t.dl = dl_i;   t.bt = bt_i;   t.ern = ern_i; t.ew = ew_i;
        t.em = em_i;   t.mrn = mrn_i; t.mw = mw_i; t.mm = mm_i;
        return t;
    endfunction

    function automatic logic [7:0] ev(input logic w, b, f, input logic [1:0] a, bb, input logic bz);
        return {w, b, f, a, bb, bz};
    endfunction

    // Independent reference for forwarding: compute both hits, then resolve priority.
    function automatic logic [1:0] ref_fwd(input logic [4:0] src, e_rn, input logic e_w, e_ld,
                                           input logic [4:0] m_rn, input logic m_w, m_ld);
        logic e_hit, m_hit;
        e_hit = (src == e_rn) && e_w && !e_ld && (src != 0);
        m_hit = (src == m_rn) && m_w && (src != 0);
        if (e_hit) return 2'b01;
        if (!m_hit) return 2'b00;
        return {1'b1, m_ld};
    endfunction

    task automatic apply(input stim_t t);
        rs = t.rs;   rt = t.rt;   use_rs = t.ur; use_rt = t.ut;
        dlong = t.dl; branch_taken = t.bt;
        ern = t.ern; ewreg = t.ew; em2reg = t.em;
        mrn = t.mrn; mwreg = t.mw; mm2reg = t.mm;
    endtask

    task automatic test_reset();
        exp_t e;
        apply(s(5, 5, 0, 0, 1, 1, 5, 1, 0, 5, 1, 0));
        sb.push_back(exp_t'{"reset", ev(1, 0, 0, 2'b00, 2'b00, 0)});
        @(negedge clock);
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
            failed++;
            $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
        end
        apply(IDLE);
        resetn = 1'b1;
    endtask

    task automatic test_forwarding();
        stim_t      tab[6];
        logic [7:0] ex[6];
        exp_t       e;
        stim_t      r;
        tab = '{s(5, 0, 0, 0, 0, 0, 5, 1, 0, 5, 1, 0),
                s(5, 0, 0, 0, 0, 0, 5, 0, 0, 5, 1, 0),
                s(5, 0, 0, 0, 0, 0, 5, 0, 0, 5, 1, 1),
                s(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0),
                s(3, 9, 0, 0, 0, 0, 9, 1, 0, 3, 1, 0),
                s(4, 0, 0, 0, 0, 0, 4, 1, 1, 4, 1, 0)};
        ex  = '{ev(1, 0, 0, 2'b01, 2'b00, 0),
                ev(1, 0, 0, 2'b10, 2'b00, 0),
                ev(1, 0, 0, 2'b11, 2'b00, 0),
                ev(1, 0, 0, 2'b00, 2'b00, 0),
                ev(1, 0, 0, 2'b10, 2'b01, 0),
                ev(1, 0, 0, 2'b10, 2'b00, 0)};
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            apply(tab[i]);
            sb.push_back(exp_t'{$sformatf("fwd%0d", i), ex[i]});
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (obs !== e.v) begin
                failed++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            r = s(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 0, 0, 0, 0,
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            apply(r);
            sb.push_back(exp_t'{$sformatf("fwd_rand%0d", i),
                ev(1, 0, 0, ref_fwd(r.rs, r.ern, r.ew, r.em, r.mrn, r.mw, r.mm),
                            ref_fwd(r.rt, r.ern, r.ew, r.em, r.mrn, r.mw, r.mm), 0)});
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (obs !== e.v) begin
                failed++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t      tab[5];
        logic [7:0] ex[5];
        exp_t       e;
        tab = '{s(0, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0),
                s(0, 7, 0, 1, 0, 0, 7, 1, 0, 0, 0, 0),
                s(0, 7, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0),
                s(6, 0, 1, 0, 0, 0, 6, 1, 1, 0, 0, 0),
                s(0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0)};
        ex  = '{ev(0, 1, 0, 2'b00, 2'b00, 0),
                ev(1, 0, 0, 2'b00, 2'b01, 0),
                ev(1, 0, 0, 2'b00, 2'b00, 0),
                ev(0, 1, 0, 2'b00, 2'b00, 0),
                ev(1, 0, 0, 2'b00, 2'b00, 0)};
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            apply(tab[i]);
            sb.push_back(exp_t'{$sformatf("load_use%0d", i), ex[i]});
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (obs !== e.v) begin
                failed++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_long_op();
        stim_t      tab[12];
        logic [7:0] ex[12];
        exp_t       e;
        tab = '{s(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0),
                s(0, 7, 0, 1, 1, 1, 7, 1, 1, 0, 0, 0),
                s(0, 7, 0, 1, 1, 1, 7, 1, 1, 0, 0, 0),
                s(2, 7, 0, 1, 1, 1, 7, 1, 1, 2, 1, 0),
                IDLE,
                s(0, 7, 0, 1, 1, 0, 7, 1, 1, 0, 0, 0),
                IDLE,
                s(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0),
                IDLE, IDLE, IDLE, IDLE};
        ex  = '{ev(1, 0, 0, 2'b00, 2'b00, 0),
                ev(0, 1, 0, 2'b00, 2'b00, 1),
                ev(0, 1, 0, 2'b00, 2'b00, 1),
                ev(0, 1, 0, 2'b10, 2'b00, 1),
                ev(1, 0, 0, 2'b00, 2'b00, 0),
                ev(0, 1, 0, 2'b00, 2'b00, 0),
                ev(1, 0, 0, 2'b00, 2'b00, 0),
                ev(1, 0, 1, 2'b00, 2'b00, 0),
                ev(0, 1, 0, 2'b00, 2'b00, 1),
                ev(0, 1, 0, 2'b00, 2'b00, 1),
                ev(0, 1, 0, 2'b00, 2'b00, 1),
                ev(1, 0, 0, 2'b00, 2'b00, 0)};
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            apply(tab[i]);
            sb.push_back(exp_t'{$sformatf("long_op%0d", i), ex[i]});
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (obs !== e.v) begin
                failed++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_branch_vs_lu();
        stim_t      tab[3];
        logic [7:0] ex[3];
        exp_t       e;
        tab = '{s(0, 7, 0, 1, 0, 1, 7, 1, 1, 0, 0, 0),
                s(0, 7, 0, 1, 0, 1, 7, 1, 0, 0, 0, 0),
                IDLE};
        ex  = '{ev(0, 1, 0, 2'b00, 2'b00, 0),
                ev(1, 0, 1, 2'b00, 2'b01, 0),
                ev(1, 0, 0, 2'b00, 2'b00, 0)};
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            apply(tab[i]);
            sb.push_back(exp_t'{$sformatf("branch_lu%0d", i), ex[i]});
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (obs !== e.v) begin
                failed++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t      tab[5];
        logic [7:0] ex[5];
        exp_t       e;
        tab = '{s(0, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0),
                s(8, 0, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0),
                s(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0),
                s(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0),
                IDLE};
        ex  = '{ev(0, 1, 0, 2'b00, 2'b00, 0),
                ev(0, 1, 0, 2'b00, 2'b00, 0),
                ev(1, 0, 1, 2'b00, 2'b00, 0),
                ev(1, 0, 1, 2'b00, 2'b00, 0),
                ev(1, 0, 0, 2'b00, 2'b00, 0)};
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            apply(tab[i]);
            sb.push_back(exp_t'{$sformatf("b2b%0d", i), ex[i]});
            @(negedge clock);
            e = sb.pop_front();
            tests++;
            if (obs !== e.v) begin
                failed++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        exp_t e;
        @(posedge clock); #1;
        apply(s(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clock); #1;
        apply(IDLE);
        @(posedge clock); #1;
        sb.push_back(exp_t'{"mid_busy_2nd", ev(0, 1, 0, 2'b00, 2'b00, 1)});
        #1;
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
            failed++;
            $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
        end
        resetn = 1'b0;
        apply(s(5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0));
        sb.push_back(exp_t'{"mid_busy_reset", ev(1, 0, 0, 2'b00, 2'b00, 0)});
        #1;
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
            failed++;
            $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
        end
        @(posedge clock);
        @(negedge clock);
        apply(IDLE);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(exp_t'{$sformatf("after_reset%0d", i), ev(1, 0, 0, 2'b00, 2'b00, 0)});
            #1;
            e = sb.pop_front();
            tests++;
            if (obs !== e.v) begin
                failed++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
            end
            @(negedge clock);
        end
    endtask

`ifdef HAZ_PERF_EN
    task automatic test_perf();
        stim_t tab[8];
        @(negedge clock);
        resetn = 1'b0;
        apply(IDLE);
        #1;
        tests++;
        if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
            failed++;
            $display("FAIL perf_reset: got stall=%0d flush=%0d expected 0/0", stall_cycles, flush_cycles);
        end
        @(negedge clock);
        resetn = 1'b1;
        tab = '{s(0, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0),
                s(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0),
                IDLE, IDLE, IDLE,
                s(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0),
                s(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0),
                IDLE};
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            apply(tab[i]);
        end
        @(negedge clock);
        tests++;
        if (stall_cycles !== 32'd4 || flush_cycles !== 32'd2) begin
            failed++;
            $display("FAIL perf_counts: got stall=%0d flush=%0d expected 4/2", stall_cycles, flush_cycles);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply(IDLE);
        test_reset();
        test_forwarding();
        test_load_use();
        test_long_op();
        test_branch_vs_lu();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef HAZ_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Decides each cycle whether the PC and IF/ID hold (wpcir), whether a bubble enters the ID/EX register (dbubble forces dwreg/dwmem/djal to 0 upstream of it), and whether the IF/ID instruction is flushed on a taken branch.
- Produces operand forwarding selects for the ID stage.
- Sequences multi-cycle (long) ALU operations with an internal busy counter.

Parameters:
- LONG_LAT, 4, total E-stage cycles of a long op (legal 2..15).

Ports:
- clock  in  1  pipeline clock, rising edge
- resetn  in  1  asynchronous active-low reset
- rs  in  5  D-stage source register A
- rt  in  5  D-stage source register B
- use_rs  in  1  D instruction reads rs
- use_rt  in  1  D instruction reads rt
- dlong  in  1  D instruction is a long op
- branch_taken  in  1  D-stage branch/jump resolved taken
- ern  in  5  E-stage destination
- ewreg  in  1  E-stage writes register
- em2reg  in  1  E-stage is a load
- mrn  in  5  M-stage destination
- mwreg  in  1  M-stage writes register
- mm2reg  in  1  M-stage is a load
- wpcir  out  1  1 = PC and IF/ID advance
- dbubble  out  1  1 = squash controls entering ID/EX
- dflush  out  1  1 = IF/ID loads a NOP
- fwda  out  2  A select: 00 regfile, 01 E ALU, 10 M ALU, 11 M memory
- fwdb  out  2  B select, same encoding
- busy  out  1  long-op sequencer active

Behaviour:
- Reset (resetn=0, asynchronous): state=RUN, cnt=0.
  - Outputs forced to: wpcir=1, dbubble=0, dflush=0, fwda=fwdb=00, busy=0.
- Forwarding (combinational, register 0 never matches). Evaluated per source: fwda for rs, fwdb for rt.
  - E match (ewreg & ~em2reg & ern==src) -> 01.
  - Else M match (mwreg & mrn==src) -> 11 if mm2reg, else 10.
  - Else 00.
  - E has priority over M.
- Load-use (combinational): lu = ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- State RUN:
  - lu=1 -> wpcir=0, dbubble=1, dflush=0. Lasts exactly one cycle per hazard. branch_taken is ignored because the branch re-evaluates next cycle.
  - Else dlong=1 -> wpcir=1. At the clock edge go to BUSY and set cnt=LONG_LAT-1. The long op itself enters ID/EX normally.
  - Else branch_taken=1 -> wpcir=1, dflush=1, dbubble=0.
  - dlong & branch_taken together -> both actions apply.
- State BUSY:
  - wpcir=0, dbubble=1, dflush=0, busy=1.
  - cnt decrements each clock; at cnt==1 the next state is RUN.
  - Total hold = LONG_LAT-1 cycles after issue.
  - lu and branch_taken are ignored. Forwarding outputs stay live.
- Only one long op can be in flight: dlong is only honoured in RUN with lu=0.
- Reset asserted mid-BUSY aborts the sequence. The first cycle after release is RUN.
- cnt is 4 bits and never wraps: it saturates at 0 in RUN.

Optional Feature:
- Macro: HAZ_PERF_EN.
- When defined, adds outputs stall_cycles [31:0] and flush_cycles [31:0]. Both reset to 0 asynchronously.
  - stall_cycles increments on each clock with wpcir=0.
  - flush_cycles increments on each clock with dflush=1.
  - Both wrap modulo 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Forwarding priority: ewreg=1, em2reg=0, ern=5, mwreg=1, mrn=5, rs=5 -> fwda=01. Then ewreg=0 -> fwda=10. Then mm2reg=1 -> fwda=11. With rs=0, ern=0 -> fwda=00.
- Load-use: ewreg=1, em2reg=1, ern=7, rt=7, use_rt=1 -> one cycle wpcir=0, dbubble=1. Next cycle em2reg=0 -> wpcir=1. Same setup with use_rt=0 -> no stall.
- Long op (LONG_LAT=4): dlong=1 in RUN -> busy=1 with wpcir=0 for 3 cycles, then RUN with wpcir=1. lu and branch_taken asserted during BUSY produce no dflush.
- Branch vs load-use: branch_taken=1 with lu=1 -> dflush=0, wpcir=0. Next cycle lu=0 -> dflush=1, wpcir=1.
- Reset mid-BUSY: assert resetn=0 on the 2nd busy cycle -> outputs immediately go to wpcir=1, busy=0. After release, dlong=0 -> stays RUN.
- HAZ_PERF_EN: one load-use stall, one 4-cycle long op, two taken branches -> stall_cycles=4, flush_cycles=2.
